// File: rtl/mac_sequencer.sv
// Sequences one MAC_UNIT through a multi-channel accumulation job: streams operand
// pairs round-robin over up to four accumulators, drains the MAC pipeline, snapshots
// the accumulators and returns one result per channel over a valid/ready interface.
module mac_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned LEN_WIDTH    = 10,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic                    Clk,
    input  logic                    rst,
    // Job control
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    cfg_len,
    input  logic [1:0]              cfg_nch,
    output logic                    busy,
    output logic                    done,
    // Operand stream
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_act,
    input  logic [DATA_WIDTH-1:0]   op_weight,
    // MAC_UNIT interface
    output logic [DATA_WIDTH-1:0]   mac_act,
    output logic [DATA_WIDTH-1:0]   mac_weight,
    output logic                    mac_block,
    output logic [1:0]              mac_select,
    input  logic [4*DATA_WIDTH-1:0] mac_out_0,
    input  logic [4*DATA_WIDTH-1:0] mac_out_1,
    input  logic [4*DATA_WIDTH-1:0] mac_out_2,
    input  logic [4*DATA_WIDTH-1:0] mac_out_3,
    // Result stream
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [4*DATA_WIDTH-1:0] res_data,
    output logic [1:0]              res_ch
);

    localparam int unsigned ResW   = 4 * DATA_WIDTH;
    localparam int unsigned BeatW  = LEN_WIDTH + 2;
    localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1) + 1;

    typedef logic [BeatW-1:0] beat_t;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StDrain,
        StCapture,
        StOutput
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        nch_q, nch_d;
    beat_t             last_q, last_d;
    beat_t             beat_q, beat_d;
    logic [1:0]        ch_q, ch_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [1:0]        idx_q, idx_d;
    logic [ResW-1:0]   snap_q [4];
    logic [ResW-1:0]   snap_d [4];

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] mac_act_q, mac_act_d;
    logic [DATA_WIDTH-1:0] mac_weight_q, mac_weight_d;
    logic                  mac_block_q, mac_block_d;
    logic [1:0]            mac_select_q, mac_select_d;
    logic [ResW-1:0]       res_data_q, res_data_d;
    logic [1:0]            res_ch_q, res_ch_d;

    // Next-state and registered-output decode for the job FSM.
    always_comb begin
        state_d      = state_q;
        nch_d        = nch_q;
        last_d       = last_q;
        beat_d       = beat_q;
        ch_d         = ch_q;
        drain_d      = drain_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        done_d       = 1'b0;
        // Idle operand slots feed zeros so the selected accumulator adds nothing.
        mac_act_d    = '0;
        mac_weight_d = '0;
        mac_select_d = mac_select_q;
        res_data_d   = res_data_q;
        res_ch_d     = res_ch_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    nch_d  = cfg_nch;
                    // Index of the final beat; unused when cfg_len is zero.
                    last_d = beat_t'(cfg_len) * (beat_t'(cfg_nch) + beat_t'(1)) - beat_t'(1);
                    beat_d = '0;
                    ch_d   = '0;
                    state_d = (cfg_len == '0) ? StCapture : StRun;
                end
            end
            StRun: begin
                if (op_valid) begin
                    mac_act_d    = op_act;
                    mac_weight_d = op_weight;
                    mac_select_d = ch_q;
                    ch_d         = (ch_q == nch_q) ? 2'd0 : ch_q + 2'd1;
                    beat_d       = beat_q + beat_t'(1);
                    if (beat_q == last_q) begin
                        drain_d = '0;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // First drain cycle carries the final operands; DRAIN_CYCLES zero cycles follow.
                if (drain_q == DrainW'(DRAIN_CYCLES)) begin
                    state_d = StCapture;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StCapture: begin
                snap_d[0]  = mac_out_0;
                snap_d[1]  = mac_out_1;
                snap_d[2]  = mac_out_2;
                snap_d[3]  = mac_out_3;
                idx_d      = '0;
                res_data_d = mac_out_0;
                res_ch_d   = '0;
                state_d    = StOutput;
            end
            StOutput: begin
                if (res_ready) begin
                    if (idx_q == nch_q) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        res_data_d = snap_q[idx_q + 2'd1];
                        res_ch_d   = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d      = (state_d != StIdle);
        mac_block_d = (state_d == StRun) || (state_d == StDrain);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_q      <= StIdle;
            nch_q        <= '0;
            last_q       <= '0;
            beat_q       <= '0;
            ch_q         <= '0;
            drain_q      <= '0;
            idx_q        <= '0;
            for (int i = 0; i < 4; i++) snap_q[i] <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mac_act_q    <= '0;
            mac_weight_q <= '0;
            mac_block_q  <= 1'b0;
            mac_select_q <= '0;
            res_data_q   <= '0;
            res_ch_q     <= '0;
        end else begin
            state_q      <= state_d;
            nch_q        <= nch_d;
            last_q       <= last_d;
            beat_q       <= beat_d;
            ch_q         <= ch_d;
            drain_q      <= drain_d;
            idx_q        <= idx_d;
            for (int i = 0; i < 4; i++) snap_q[i] <= snap_d[i];
            busy_q       <= busy_d;
            done_q       <= done_d;
            mac_act_q    <= mac_act_d;
            mac_weight_q <= mac_weight_d;
            mac_block_q  <= mac_block_d;
            mac_select_q <= mac_select_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign op_ready   = (state_q == StRun);
    assign mac_act    = mac_act_q;
    assign mac_weight = mac_weight_q;
    assign mac_block  = mac_block_q;
    assign mac_select = mac_select_q;
    assign res_valid  = (state_q == StOutput);
    assign res_data   = res_data_q;
    assign res_ch     = res_ch_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with a two-stage behavioural MAC model.
module tb_mac_sequencer;

    logic        Clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  cfg_len;
    logic [1:0]  cfg_nch;
    logic        busy, done;
    logic        op_valid, op_ready;
    logic [7:0]  op_act, op_weight;
    logic [7:0]  mac_act, mac_weight;
    logic        mac_block;
    logic [1:0]  mac_select;
    logic [31:0] mac_out_0, mac_out_1, mac_out_2, mac_out_3;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_ch;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_cnt = 0;

    mac_sequencer dut (
        .Clk        (Clk),
        .rst        (rst),
        .start      (start),
        .cfg_len    (cfg_len),
        .cfg_nch    (cfg_nch),
        .busy       (busy),
        .done       (done),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_act     (op_act),
        .op_weight  (op_weight),
        .mac_act    (mac_act),
        .mac_weight (mac_weight),
        .mac_block  (mac_block),
        .mac_select (mac_select),
        .mac_out_0  (mac_out_0),
        .mac_out_1  (mac_out_1),
        .mac_out_2  (mac_out_2),
        .mac_out_3  (mac_out_3),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ch     (res_ch)
    );

    always #5 Clk = ~Clk;

    // MAC model: product register, then accumulate; Block_control low clears.
    logic [31:0] acc [4];
    logic [15:0] prod_q;
    logic [1:0]  sel_q;
    logic        en_q;

    always @(posedge Clk) begin
        prod_q <= 16'(mac_act) * 16'(mac_weight);
        sel_q  <= mac_select;
        en_q   <= rst ? 1'b0 : mac_block;
        if (rst || !mac_block) begin
            for (int i = 0; i < 4; i++) acc[i] <= '0;
        end else if (en_q) begin
            acc[sel_q] <= acc[sel_q] + 32'(prod_q);
        end
    end

    assign mac_out_0 = acc[0];
    assign mac_out_1 = acc[1];
    assign mac_out_2 = acc[2];
    assign mac_out_3 = acc[3];

    always @(posedge Clk) cyc <= cyc + 1;
    always @(negedge Clk) if (op_ready) ready_cnt <= ready_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic start_job(input logic [9:0] len, input logic [1:0] nch);
        start   = 1'b1;
        cfg_len = len;
        cfg_nch = nch;
        @(negedge Clk);
        start   = 1'b0;
        cfg_len = '0;
        cfg_nch = '0;
    endtask

    // Idle for gap cycles (optionally checking zero operands), then present one beat.
    task automatic send_beat(input logic [7:0] a, input logic [7:0] w, input int gap,
                             input bit chk_gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            op_valid  = 1'b0;
            op_act    = '0;
            op_weight = '0;
            if (chk_gap && i > 0) begin
                check_val("gap_mac_act", 32'(mac_act), 32'd0);
                check_val("gap_mac_weight", 32'(mac_weight), 32'd0);
            end
            @(negedge Clk);
        end
        op_valid  = 1'b1;
        op_act    = a;
        op_weight = w;
        n = 0;
        while (!op_ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) check_val("op_ready_wait", 32'(op_ready), 32'd1);
        @(negedge Clk);
        op_valid  = 1'b0;
        op_act    = '0;
        op_weight = '0;
    endtask

    // Wait for a result, compare it, optionally hold off res_ready, then accept it.
    task automatic get_result(input logic [1:0] ch, input logic [31:0] exp, input int stall);
        int n;
        res_ready = (stall == 0);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge Clk);
            n++;
        end
        check_val("res_valid", 32'(res_valid), 32'd1);
        check_val("res_ch", 32'(res_ch), 32'(ch));
        check_val("res_data", res_data, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge Clk);
            check_val("stall_valid", 32'(res_valid), 32'd1);
            check_val("stall_data", res_data, exp);
            check_val("stall_ch", 32'(res_ch), 32'(ch));
        end
        res_ready = 1'b1;
        @(negedge Clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int t0;
        int rc0;
        rst       = 1'b1;
        start     = 1'b0;
        cfg_len   = '0;
        cfg_nch   = '0;
        op_valid  = 1'b0;
        op_act    = '0;
        op_weight = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge Clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_op_ready", 32'(op_ready), 32'd0);
        check_val("rst_mac_block", 32'(mac_block), 32'd0);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        @(negedge Clk);

        // Single channel, back-to-back, with latency check.
        t0 = cyc;
        start_job(10'd3, 2'd0);
        check_val("s1_busy", 32'(busy), 32'd1);
        check_val("s1_mac_block", 32'(mac_block), 32'd1);
        send_beat(8'd2, 8'd3, 0, 1'b0);
        send_beat(8'd4, 8'd5, 0, 1'b0);
        send_beat(8'd1, 8'd7, 0, 1'b0);
        get_result(2'd0, 32'd33, 0);
        check_val("s1_done", 32'(done), 32'd1);
        check_val("s1_busy_low", 32'(busy), 32'd0);
        check_val("s1_latency", 32'(cyc - t0), 32'd9);
        @(negedge Clk);
        check_val("s1_done_pulse", 32'(done), 32'd0);

        // Four channels interleaved round-robin.
        start_job(10'd2, 2'd3);
        for (int r = 0; r < 2; r++) begin
            send_beat(8'd1, 8'd1, 0, 1'b0);
            send_beat(8'd2, 8'd2, 0, 1'b0);
            send_beat(8'd3, 8'd3, 0, 1'b0);
            send_beat(8'd10, 8'd10, 0, 1'b0);
        end
        get_result(2'd0, 32'd2, 0);
        get_result(2'd1, 32'd8, 0);
        get_result(2'd2, 32'd18, 0);
        get_result(2'd3, 32'd200, 0);
        check_val("s2_done", 32'(done), 32'd1);
        @(negedge Clk);

        // Operand gaps and result back-pressure.
        start_job(10'd3, 2'd0);
        send_beat(8'd2, 8'd3, 0, 1'b0);
        send_beat(8'd4, 8'd5, 3, 1'b1);
        send_beat(8'd1, 8'd7, 3, 1'b1);
        get_result(2'd0, 32'd33, 4);
        check_val("s3_done", 32'(done), 32'd1);
        @(negedge Clk);

        // Zero length: no operand acceptance, zero results.
        rc0 = ready_cnt;
        start_job(10'd0, 2'd1);
        get_result(2'd0, 32'd0, 0);
        get_result(2'd1, 32'd0, 0);
        check_val("s4_done", 32'(done), 32'd1);
        check_val("s4_no_op_ready", 32'(ready_cnt - rc0), 32'd0);
        @(negedge Clk);

        // Start pulse during RUN is ignored.
        start_job(10'd2, 2'd1);
        send_beat(8'd3, 8'd4, 0, 1'b0);
        start   = 1'b1;
        cfg_len = 10'd1;
        cfg_nch = 2'd3;
        @(negedge Clk);
        start   = 1'b0;
        cfg_len = '0;
        cfg_nch = '0;
        send_beat(8'd5, 8'd6, 0, 1'b0);
        send_beat(8'd1, 8'd1, 0, 1'b0);
        send_beat(8'd2, 8'd2, 0, 1'b0);
        get_result(2'd0, 32'd13, 0);
        get_result(2'd1, 32'd34, 0);
        check_val("s5_done", 32'(done), 32'd1);
        repeat (3) @(negedge Clk);
        check_val("s5_stays_idle", 32'(busy), 32'd0);
        check_val("s5_no_extra_res", 32'(res_valid), 32'd0);

        // Reset mid-job after 2 of 6 beats.
        start_job(10'd3, 2'd1);
        send_beat(8'd9, 8'd9, 0, 1'b0);
        send_beat(8'd7, 8'd7, 0, 1'b0);
        rst = 1'b1;
        @(negedge Clk);
        rst = 1'b0;
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_done", 32'(done), 32'd0);
        check_val("mid_op_ready", 32'(op_ready), 32'd0);
        check_val("mid_mac_block", 32'(mac_block), 32'd0);
        check_val("mid_res_valid", 32'(res_valid), 32'd0);
        check_val("mid_mac_act", 32'(mac_act), 32'd0);
        check_val("mid_mac_weight", 32'(mac_weight), 32'd0);
        check_val("mid_mac_select", 32'(mac_select), 32'd0);
        check_val("mid_res_data", res_data, 32'd0);
        check_val("mid_res_ch", 32'(res_ch), 32'd0);
        @(negedge Clk);
        check_val("mid_res_valid2", 32'(res_valid), 32'd0);
        start_job(10'd1, 2'd0);
        send_beat(8'd255, 8'd255, 0, 1'b0);
        get_result(2'd0, 32'd65025, 0);
        check_val("mid_new_done", 32'(done), 32'd1);
        @(negedge Clk);

        // Maximum length with maximum operands.
        start_job(10'd1023, 2'd0);
        for (int i = 0; i < 1023; i++) send_beat(8'd255, 8'd255, 0, 1'b0);
        get_result(2'd0, 32'd66520575, 0);
        check_val("sat_done", 32'(done), 32'd1);
        @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Controller that sequences one MAC_UNIT datapath through a complete multi-channel accumulation job.
- Accepts a job command, then streams activation/weight pairs into the MAC, interleaving them round-robin across up to 4 accumulators.
- Drains the MAC pipeline, snapshots the accumulator outputs with a one-cycle Block_control-low window, and returns one result per channel over a valid/ready interface.
- Sits between the operand buffer/scheduler and the MAC_UNIT.

Parameters:
- DATA_WIDTH, 8, operand width; accumulator/result width is 4*DATA_WIDTH.
- LEN_WIDTH, 10, width of the per-channel product count.
- DRAIN_CYCLES, 2, zero-operand cycles with mac_block high after the last operand beat.

Ports:
- Clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  job start pulse; sampled only in IDLE.
- cfg_len  in  LEN_WIDTH  products per channel.
- cfg_nch  in  2  number of channels minus 1 (0..3 -> 1..4).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last result transfers.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted when op_valid && op_ready.
- op_act  in  DATA_WIDTH  activation.
- op_weight  in  DATA_WIDTH  weight.
- mac_act  out  DATA_WIDTH  to MAC Input_act.
- mac_weight  out  DATA_WIDTH  to MAC Input_weight.
- mac_block  out  1  to MAC Block_control.
- mac_select  out  2  to MAC Select.
- mac_out_0..mac_out_3  in  4*DATA_WIDTH each  from MAC Output_0..Output_3.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted when res_valid && res_ready.
- res_data  out  4*DATA_WIDTH  accumulated result.
- res_ch  out  2  channel index of res_data.

Behaviour:
- Registered outputs: all outputs are registered except op_ready and res_valid, which decode directly from state.
- Reset: state IDLE. busy, done, op_ready, mac_block, res_valid = 0. mac_act, mac_weight, mac_select, res_data, res_ch = 0. Counters and snapshot registers = 0.
- Reset mid-job: abandons the job in the same edge and returns to IDLE with the values above. No partial result is emitted. mac_block = 0 in IDLE keeps the MAC accumulators cleared.
- States: IDLE, RUN, DRAIN, CAPTURE, OUTPUT.
- IDLE:
  - On start, latch cfg_len and cfg_nch.
  - If cfg_len == 0, go to CAPTURE; otherwise go to RUN.
  - mac_block = 0.
  - start outside IDLE is ignored.
- RUN:
  - op_ready = 1; mac_block = 1.
  - Each accepted beat registers op_act/op_weight onto mac_act/mac_weight and the current channel onto mac_select, visible the next cycle.
  - Channel counter increments modulo (cfg_nch+1).
  - Beat counter counts to cfg_len*(cfg_nch+1). The product uses LEN_WIDTH+2 bits, so there is no overflow.
  - Cycles with no accepted beat drive mac_act = mac_weight = 0 and hold mac_select (adds 0).
  - On accepting the final beat, go to DRAIN.
- DRAIN:
  - op_ready = 0; mac_block = 1; mac_act = mac_weight = 0; mac_select held.
  - Lasts exactly DRAIN_CYCLES cycles, counted from the first cycle after the final beat's operands appear on mac_*. Then go to CAPTURE.
- CAPTURE:
  - Exactly one cycle with mac_block = 0.
  - At the end of this cycle, mac_out_0..mac_out_3 are sampled into four snapshot registers. The MAC clears its accumulators on the same edge.
  - Go to OUTPUT with the output index = 0.
- OUTPUT:
  - mac_block = 0; res_valid = 1; res_data = snapshot[index]; res_ch = index.
  - On handshake, the index increments. res_data/res_ch update in the same edge, so there are no bubbles.
  - res_data and res_ch hold stable while res_valid && !res_ready.
  - When the index equals cfg_nch at handshake, go to IDLE with done = 1 for one cycle.
  - Channels above cfg_nch are never emitted.
- Total latency for a job with no stalls: 1 + cfg_len*(cfg_nch+1) + 1 + DRAIN_CYCLES + 1 + (cfg_nch+1) cycles from start to done.
- Arithmetic: products and sums are computed in the MAC only. The sequencer does not modify data; it passes the snapshot through unchanged.

Test Plan:
- Single channel: start, cfg_nch=0, cfg_len=3; pairs (2,3),(4,5),(1,7) back-to-back, res_ready=1 -> one result, res_ch=0, res_data=33; done one cycle after; busy low next cycle.
- Four channels interleaved: cfg_nch=3, cfg_len=2; pairs ch0:(1,1),(1,1) ch1:(2,2),(2,2) ch2:(3,3),(3,3) ch3:(10,10),(10,10) -> results in order ch0=2, ch1=8, ch2=18, ch3=200; no cycle with mac_block=1 and mac_select outside 0..3.
- Stalls: same as scenario 1, op_valid low for 3 cycles between each beat and res_ready low 4 cycles -> result still 33; res_data stable while stalled; mac_act=mac_weight=0 in gap cycles.
- Zero length and ignored start: cfg_len=0, cfg_nch=1 -> no op_ready pulse, results ch0=0, ch1=0; start pulse during RUN of a job -> no effect on that job.
- Reset mid-job: rst high for 1 cycle after 2 of 6 beats -> all outputs at reset values next cycle, no res_valid. A new job with cfg_nch=0, cfg_len=1, (255,255) then yields 65025, with no residue from the aborted job.
- Saturating values: cfg_nch=0, cfg_len=1023, all pairs (255,255) -> res_data = 1023*65025 = 66520575, fits in 32 bits.
